leaf_packet_tx: RTL and testbench

- User-to-BFT transmit packetizer for a single output stream of a leaf.
- Accepts 32-bit words from an HLS kernel output port over an ap_vld/ap_ack handshake.
- Wraps each word into a 49-bit BFT packet addressed to a configured destination leaf and port.
- Uses credit-based flow control: destination free-space updates arriving on the BFT input replenish a credit counter that gates transmission.

---
 rtl/leaf_packet_tx_if.sv | 40 ++++
 rtl/leaf_packet_tx.sv | 139 +++++++++++++
 tb/tb_leaf_packet_tx.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/leaf_packet_tx_if.sv
// leaf_packet_tx_if: signal bundle between an HLS kernel output port, the
// BFT fabric and the leaf transmit packetizer.
//   cfg_dst_leaf / cfg_dst_port    static destination of every packet
//   din_user / din_user_ap_vld     user word and its valid strobe
//   din_user_ap_ack                word taken this cycle
//   dout_leaf_interface2bft        outbound packet, MSB is the valid bit
//   out_ready                      fabric takes the outbound packet this cycle
//   din_leaf_bft2interface         inbound packet, watched for credit returns
//   resend                         re-emit request for the last handed-off packet
//   credit_overflow                sticky credit saturation flag
// The slave modport is the packetizer; the master modport is its environment.
interface leaf_packet_tx_if #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4
);
  logic [NUM_LEAF_BITS-1:0] cfg_dst_leaf;
  logic [NUM_PORT_BITS-1:0] cfg_dst_port;
  logic [PAYLOAD_BITS-1:0]  din_user;
  logic                     din_user_ap_vld;
  logic                     din_user_ap_ack;
  logic [PACKET_BITS-1:0]   dout_leaf_interface2bft;
  logic                     out_ready;
  logic [PACKET_BITS-1:0]   din_leaf_bft2interface;
  logic                     resend;
  logic                     credit_overflow;

  modport master (
    output cfg_dst_leaf, cfg_dst_port, din_user, din_user_ap_vld, out_ready,
           din_leaf_bft2interface, resend,
    input  din_user_ap_ack, dout_leaf_interface2bft, credit_overflow
  );

  modport slave (
    input  cfg_dst_leaf, cfg_dst_port, din_user, din_user_ap_vld, out_ready,
           din_leaf_bft2interface, resend,
    output din_user_ap_ack, dout_leaf_interface2bft, credit_overflow
  );
endinterface

// File: rtl/leaf_packet_tx.sv
// leaf_packet_tx: user-to-BFT transmit packetizer for one leaf output stream.
// Each accepted 32-bit user word is wrapped into a 49-bit packet
// {valid, dst_leaf, dst_port, seq_addr, payload} and presented one cycle
// later. Transmission is gated by a credit counter that starts at the
// receiver buffer depth and is replenished by inbound credit packets
// (valid with addr == CREDIT_ADDR, increment in payload[7:0]).
// Ports:
//   clk_bft   sole clock
//   reset     asynchronous, active-low reset
//   bus       leaf_packet_tx_if.slave (user handshake, outbound/inbound
//             BFT packets, resend, credit_overflow)
// Optional feature macro: LEAF_TX_RESEND_EN -- keeps a shadow copy of the
// last handed-off packet and re-emits it on a resend pulse while idle.
module leaf_packet_tx #(
  parameter int PACKET_BITS        = 49,
  parameter int PAYLOAD_BITS       = 32,
  parameter int NUM_LEAF_BITS      = 5,
  parameter int NUM_PORT_BITS      = 4,
  parameter int NUM_ADDR_BITS      = 7,
  parameter int NUM_BRAM_ADDR_BITS = 7,
  parameter logic [NUM_ADDR_BITS-1:0] CREDIT_ADDR = 7'h7F
) (
  input logic             clk_bft,
  input logic             reset,
  leaf_packet_tx_if.slave bus
);

  localparam int CREDIT_W   = NUM_BRAM_ADDR_BITS + 1;
  localparam int SUM_W      = NUM_BRAM_ADDR_BITS + 3;
  localparam int MAX_CREDIT = 1 << NUM_BRAM_ADDR_BITS;

  typedef enum logic {IDLE, FULL} state_t;

  state_t                   state, state_nxt;
  logic [PACKET_BITS-1:0]   pkt_p0, pkt_nxt;
  logic [NUM_ADDR_BITS-1:0] seq_addr, seq_addr_nxt;
  logic [CREDIT_W-1:0]      credit, credit_nxt;
  logic                     credit_overflow_r, credit_overflow_nxt;

  logic                     accept;
  logic                     handoff;
  logic                     do_resend;
  logic [PACKET_BITS-1:0]   resend_pkt;
  logic [7:0]               credit_inc;
  logic [SUM_W-1:0]         credit_sum;
  logic [CREDIT_W:0]        credit_sat;
  logic                     unused_inbound;

  // Clamp the raw credit sum to the buffer depth; MSB of the result flags
  // that clamping happened.
  function automatic logic [CREDIT_W:0] sat_credit(input logic [SUM_W-1:0] sum);
    if (sum > SUM_W'(MAX_CREDIT))
      return {1'b1, CREDIT_W'(MAX_CREDIT)};
    return {1'b0, sum[CREDIT_W-1:0]};
  endfunction

  // ack is held low during reset so no word is lost while the block is
  // being cleared.
  assign accept = reset && bus.din_user_ap_vld && (credit != '0) &&
                  (state == IDLE || bus.out_ready);
  assign handoff = (state == FULL) && bus.out_ready;

  assign credit_inc =
    (bus.din_leaf_bft2interface[PACKET_BITS-1] &&
     bus.din_leaf_bft2interface[PAYLOAD_BITS +: NUM_ADDR_BITS] == CREDIT_ADDR)
      ? bus.din_leaf_bft2interface[7:0] : 8'd0;

  // Accept consumes one credit; accept implies credit != 0, so no underflow.
  assign credit_sum = SUM_W'(credit) + SUM_W'(credit_inc) - SUM_W'(accept);
  assign credit_sat = sat_credit(credit_sum);

`ifdef LEAF_TX_RESEND_EN
  logic [PACKET_BITS-1:0] shadow_pkt;
  logic                   shadow_vld;

  always_ff @(posedge clk_bft or negedge reset) begin
    if (!reset) begin
      shadow_pkt <= '0;
      shadow_vld <= 1'b0;
    end else if (handoff) begin
      shadow_pkt <= pkt_p0;
      shadow_vld <= 1'b1;
    end
  end

  // A new user word wins over a resend request in the same idle cycle.
  assign do_resend  = (state == IDLE) && bus.resend && shadow_vld && !accept;
  assign resend_pkt = shadow_pkt;
  assign unused_inbound = ^{bus.din_leaf_bft2interface[PACKET_BITS-2:PAYLOAD_BITS+NUM_ADDR_BITS],
                            bus.din_leaf_bft2interface[PAYLOAD_BITS-1:8]};
`else
  assign do_resend  = 1'b0;
  assign resend_pkt = '0;
  assign unused_inbound = ^{bus.din_leaf_bft2interface[PACKET_BITS-2:PAYLOAD_BITS+NUM_ADDR_BITS],
                            bus.din_leaf_bft2interface[PAYLOAD_BITS-1:8], bus.resend};
`endif

  always_comb begin
    state_nxt           = state;
    pkt_nxt             = pkt_p0;
    seq_addr_nxt        = seq_addr;
    credit_nxt          = credit_sat[CREDIT_W-1:0];
    credit_overflow_nxt = credit_overflow_r | credit_sat[CREDIT_W];
    if (accept) begin
      // Also covers back-to-back: FULL with out_ready reloads in place.
      pkt_nxt      = {1'b1, bus.cfg_dst_leaf, bus.cfg_dst_port, seq_addr, bus.din_user};
      seq_addr_nxt = seq_addr + NUM_ADDR_BITS'(1);
      state_nxt    = FULL;
    end else if (do_resend) begin
      pkt_nxt   = resend_pkt;
      state_nxt = FULL;
    end else if (handoff) begin
      pkt_nxt[PACKET_BITS-1] = 1'b0;
      state_nxt              = IDLE;
    end
  end

  // ---- output register stage (p0) ----
  always_ff @(posedge clk_bft or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      pkt_p0            <= '0;
      seq_addr          <= '0;
      credit            <= CREDIT_W'(MAX_CREDIT);
      credit_overflow_r <= 1'b0;
    end else begin
      state             <= state_nxt;
      pkt_p0            <= pkt_nxt;
      seq_addr          <= seq_addr_nxt;
      credit            <= credit_nxt;
      credit_overflow_r <= credit_overflow_nxt;
    end
  end

  assign bus.din_user_ap_ack         = accept;
  assign bus.dout_leaf_interface2bft = pkt_p0;
  assign bus.credit_overflow         = credit_overflow_r;

endmodule

// File: tb/tb_leaf_packet_tx.sv
module tb_leaf_packet_tx;
  logic clk_bft = 1'b0;
  logic reset   = 1'b0;
  always #5 clk_bft = ~clk_bft;

  leaf_packet_tx_if bus ();
  leaf_packet_tx dut (.clk_bft(clk_bft), .reset(reset), .bus(bus));

  int checks   = 0;
  int failures = 0;

  logic [48:0] exp_q[$];
  logic [6:0]  seen_addr[$];
  int          acc_count = 0;

  // Reference model state (spec-level: a credit integer, a sequence number,
  // an occupied/empty output slot and the last packet handed to the fabric).
  int          m_credit    = 128;
  int          m_addr      = 0;
  bit          m_full      = 0;
  bit          m_ovf       = 0;
  logic [48:0] m_cur       = '0;
  logic [48:0] m_last      = '0;
  bit          m_have_last = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [48:0] credit_pkt(input int n);
    return {1'b1, 9'($urandom), 7'h7F, 24'($urandom), 8'(n)};
  endfunction

  // Reference model: predicts ack each cycle, pushes expected packets.
  always @(negedge clk_bft) begin
    bit          exp_ack;
    bit          handoff;
    int          inc;
    logic [48:0] in_pkt;
    if (!reset) begin
      m_credit = 128; m_addr = 0; m_full = 0; m_ovf = 0; m_have_last = 0;
      exp_q.delete();
      chk("reset_dout", bus.dout_leaf_interface2bft, 0);
      chk("reset_ack", bus.din_user_ap_ack, 0);
      chk("reset_ovf", bus.credit_overflow, 0);
    end else begin
      exp_ack = bus.din_user_ap_vld && (m_credit > 0) && (!m_full || bus.out_ready);
      chk("ack", bus.din_user_ap_ack, exp_ack);
      chk("dout_valid", bus.dout_leaf_interface2bft[48], m_full);
      chk("overflow", bus.credit_overflow, m_ovf);
      if (bus.din_user_ap_ack) acc_count++;
      handoff = m_full && bus.out_ready;
      in_pkt  = bus.din_leaf_bft2interface;
      inc     = (in_pkt[48] && in_pkt[38:32] == 7'h7F) ? int'(in_pkt[7:0]) : 0;
      if (handoff) begin
        m_last = m_cur;
        m_have_last = 1;
      end
      if (exp_ack) begin
        m_cur = {1'b1, bus.cfg_dst_leaf, bus.cfg_dst_port, 7'(m_addr), bus.din_user};
        exp_q.push_back(m_cur);
        m_addr = (m_addr + 1) % 128;
        m_full = 1;
      end
`ifdef LEAF_TX_RESEND_EN
      else if (!m_full && bus.resend && m_have_last) begin
        m_cur = m_last;
        exp_q.push_back(m_cur);
        m_full = 1;
      end
`endif
      else if (handoff) begin
        m_full = 0;
      end
      m_credit = m_credit - (exp_ack ? 1 : 0) + inc;
      if (m_credit > 128) begin
        m_credit = 128;
        m_ovf = 1;
      end
    end
  end

  // Monitor: every packet the fabric takes must match the scoreboard head.
  always @(negedge clk_bft) begin
    logic [48:0] e;
    if (reset && bus.dout_leaf_interface2bft[48] && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pkt actual=%0h required=none", bus.dout_leaf_interface2bft);
      end else begin
        e = exp_q.pop_front();
        chk("pkt", bus.dout_leaf_interface2bft, e);
        seen_addr.push_back(bus.dout_leaf_interface2bft[38:32]);
      end
    end
  end

  task automatic tick();
    @(posedge clk_bft);
    #1;
  endtask

  task automatic idle_inputs();
    bus.din_user_ap_vld = 1'b0;
    bus.out_ready = 1'b1;
    bus.din_leaf_bft2interface = '0;
    bus.resend = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic stream(input int n, output int accepted);
    int start;
    start = acc_count;
    bus.din_user_ap_vld = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.din_user = $urandom;
      tick();
    end
    bus.din_user_ap_vld = 1'b0;
    accepted = acc_count - start;
  endtask

  initial begin
    int  a;
    bit  found;
    int  r;
    bus.cfg_dst_leaf = 5'd5;
    bus.cfg_dst_port = 4'd2;
    bus.din_user = '0;
    idle_inputs();
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Single word: ack now, packet next cycle.
    bus.din_user = 32'hDEADBEEF;
    bus.din_user_ap_vld = 1'b1;
    @(negedge clk_bft);
    chk("first_ack", bus.din_user_ap_ack, 1);
    tick();
    bus.din_user_ap_vld = 1'b0;
    @(negedge clk_bft);
    chk("first_pkt", bus.dout_leaf_interface2bft, {1'b1, 5'd5, 4'd2, 7'd0, 32'hDEADBEEF});
    tick();

    // Exhaustion: 127 credits remain after the first word.
    stream(140, a);
    chk("credits_after_first", a, 127);

    // Credit return of 64 while a word is waiting.
    bus.din_user_ap_vld = 1'b1;
    bus.din_leaf_bft2interface = credit_pkt(64);
    tick();
    bus.din_leaf_bft2interface = '0;
    @(negedge clk_bft);
    chk("ack_after_return", bus.din_user_ap_ack, 1);
    tick();
    stream(80, a);
    chk("credits_after_return", a, 63);

    // Backpressure: refill, then hold out_ready low for 5 cycles.
    bus.din_leaf_bft2interface = credit_pkt(128);
    tick();
    bus.din_leaf_bft2interface = '0;
    bus.out_ready = 1'b0;
    bus.din_user = 32'hCAFE0001;
    bus.din_user_ap_vld = 1'b1;
    @(negedge clk_bft);
    chk("bp_first_ack", bus.din_user_ap_ack, 1);
    tick();
    bus.din_user = 32'h0BAD0BAD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_bft);
      chk("bp_hold", bus.dout_leaf_interface2bft, m_cur);
      chk("bp_ack", bus.din_user_ap_ack, 0);
      tick();
    end
    idle_inputs();
    repeat (2) tick();

    // Wrap-around: 130 words, one credit returned per cycle.
    seen_addr.delete();
    bus.din_user_ap_vld = 1'b1;
    for (int i = 0; i < 130; i++) begin
      bus.din_user = $urandom;
      bus.din_leaf_bft2interface = credit_pkt(1);
      tick();
    end
    idle_inputs();
    repeat (3) tick();
    found = 0;
    for (int i = 0; i + 3 < seen_addr.size(); i++)
      if (seen_addr[i] == 7'd126 && seen_addr[i+1] == 7'd127 &&
          seen_addr[i+2] == 7'd0 && seen_addr[i+3] == 7'd1) found = 1;
    chk("addr_wrap_seq", found, 1);

    // Simultaneous accept and +64 at credit 10 -> 73.
    do_reset();
    stream(118, a);
    chk("drain_to_10", a, 118);
    bus.din_user_ap_vld = 1'b1;
    bus.din_user = 32'h5A5A5A5A;
    bus.din_leaf_bft2interface = credit_pkt(64);
    tick();
    bus.din_leaf_bft2interface = '0;
    stream(90, a);
    chk("credits_after_simul", a, 73);

    // Overflow: +64 at credit 100 saturates at 128.
    do_reset();
    stream(28, a);
    @(negedge clk_bft);
    chk("ovf_before", bus.credit_overflow, 0);
    tick();
    bus.din_leaf_bft2interface = credit_pkt(64);
    tick();
    bus.din_leaf_bft2interface = '0;
    @(negedge clk_bft);
    chk("ovf_after", bus.credit_overflow, 1);
    tick();
    stream(140, a);
    chk("credits_after_ovf", a, 128);

    // Asynchronous reset while FULL.
    idle_inputs();
    tick();
    bus.out_ready = 1'b0;
    bus.din_leaf_bft2interface = credit_pkt(4);
    bus.din_user_ap_vld = 1'b1;
    tick();
    bus.din_user_ap_vld = 1'b0;
    bus.din_leaf_bft2interface = '0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_dout", bus.dout_leaf_interface2bft, 0);
    chk("async_reset_ovf", bus.credit_overflow, 0);
    tick();
    idle_inputs();
    reset = 1'b1;
    tick();

`ifdef LEAF_TX_RESEND_EN
    // Resend before anything was sent: ignored.
    bus.resend = 1'b1;
    tick();
    bus.resend = 1'b0;
    @(negedge clk_bft);
    chk("resend_empty", bus.dout_leaf_interface2bft[48], 0);
    tick();
    bus.din_user = 32'h12345678;
    bus.din_user_ap_vld = 1'b1;
    tick();
    bus.din_user_ap_vld = 1'b0;
    repeat (2) tick();
    bus.resend = 1'b1;
    tick();
    bus.resend = 1'b0;
    @(negedge clk_bft);
    chk("resend_pkt", bus.dout_leaf_interface2bft, {1'b1, 5'd5, 4'd2, 7'd0, 32'h12345678});
    tick();
    tick();
    stream(140, a);
    chk("credits_after_resend", a, 127);
    do_reset();
`endif

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.din_user_ap_vld = ($urandom_range(0, 3) != 0);
      bus.din_user = $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.resend = ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 15);
      if (r < 4)
        bus.din_leaf_bft2interface = credit_pkt($urandom_range(0, 4));
      else if (r == 4)
        bus.din_leaf_bft2interface = {1'b0, 9'($urandom), 7'h7F, 24'h0, 8'd50};
      else
        bus.din_leaf_bft2interface = {1'b1, 5'($urandom), 4'($urandom),
                                      7'($urandom_range(0, 126)), 32'($urandom)};
      tick();
    end
    idle_inputs();
    repeat (4) tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
